// File: rtl/sampling_inverse.sv
// Recovers epsilon = (a - ac) / sqrt(ad) per lane in signed Q4.27 using a bit-serial sqrt and divider.
// Latency: 90 cycles per lane (LOAD 1, SQRT 29, DIV 59, STORE 1); out_valid rises 90*N_input cycles after accept.
// Backpressure: results held in DONE until out_ready; in_ready returns the cycle after that handshake.
// Optional SAMPLING_INVERSE_CLAMP_EN clamps every lane result to [-4.0, +4.0].
module sampling_inverse #(
  parameter int N_input = 2,
  parameter int BITSIZE = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_input*BITSIZE-1:0] a,
  input  logic [N_input*BITSIZE-1:0] ac,
  input  logic [N_input*BITSIZE-1:0] ad,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_input*BITSIZE-1:0] epsilon,
  output logic [N_input-1:0]         div_err
);

  localparam int FRAC = BITSIZE - 5;             // fraction bits (27)
  localparam int RW   = BITSIZE - 1 + FRAC;      // radicand width (58)
  localparam int SW   = RW / 2;                  // root width (29)
  localparam int DW   = BITSIZE + FRAC;          // dividend / quotient width (59)
  localparam int RMW  = SW + 2;                  // partial remainder width
  localparam int CW   = $clog2(DW);
  localparam int LW   = (N_input > 1) ? $clog2(N_input) : 1;
  localparam logic [DW-1:0]      MAX_MAG   = DW'((64'd1 << (BITSIZE - 1)) - 64'd1);
  localparam logic [BITSIZE-1:0] MAX_MAG_W = BITSIZE'((64'd1 << (BITSIZE - 1)) - 64'd1);
  localparam logic [BITSIZE-1:0] CLAMP_MAG = BITSIZE'(64'd1 << (FRAC + 2));

  typedef enum logic [2:0] {IDLE, LOAD, SQRT, DIV, STORE, DONE} state_t;

  state_t                     state, state_nx;
  logic [N_input*BITSIZE-1:0] a_q, ac_q, ad_q;
  logic [LW-1:0]              lane;
  logic [CW-1:0]              cnt;
  logic [RW-1:0]              rad;
  logic [SW-1:0]              root;
  logic [RMW-1:0]             rem;
  logic [DW-1:0]              dvd;     // dividend shifts out the top, quotient shifts in the bottom
  logic [BITSIZE:0]           d_q;     // a - ac, one guard bit so it never overflows
  logic [N_input*BITSIZE-1:0] eps_q;
  logic [N_input-1:0]         err_q;

  logic [BITSIZE-1:0] a_i, ac_i, ad_i;
  logic [BITSIZE:0]   d_calc;
  logic [BITSIZE-1:0] d_mag;
  logic [RMW+1:0]     sq_rem, sq_trial;
  logic               sq_ge;
  logic [RMW:0]       dv_rem, dv_div;
  logic               dv_ge;
  logic [BITSIZE-1:0] mag;
  logic [BITSIZE-1:0] lane_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign epsilon   = eps_q;
  assign div_err   = err_q;

  // Select the operands of the lane currently being worked on.
  always_comb begin
    a_i  = '0;
    ac_i = '0;
    ad_i = '0;
    for (int i = 0; i < N_input; i++) begin
      if (lane == LW'(i)) begin
        a_i  = a_q[i*BITSIZE +: BITSIZE];
        ac_i = ac_q[i*BITSIZE +: BITSIZE];
        ad_i = ad_q[i*BITSIZE +: BITSIZE];
      end
    end
  end

  // One step of the sqrt and divider, plus the saturated/signed lane result.
  always_comb begin
    d_calc   = {a_i[BITSIZE-1], a_i} - {ac_i[BITSIZE-1], ac_i};
    d_mag    = d_q[BITSIZE] ? BITSIZE'(-d_q) : d_q[BITSIZE-1:0];
    sq_rem   = {rem, rad[RW-1 -: 2]};
    sq_trial = {{(RMW - SW){1'b0}}, root, 2'b01};
    sq_ge    = (sq_rem >= sq_trial);
    dv_rem   = {rem, dvd[DW-1]};
    dv_div   = {{(RMW + 1 - SW){1'b0}}, root};
    dv_ge    = (dv_rem >= dv_div);
    if (root == '0) begin
      // Zero or negative variance: quotient is meaningless, report full scale by sign.
      mag = (d_q == '0) ? '0 : MAX_MAG_W;
    end else begin
      mag = (dvd > MAX_MAG) ? MAX_MAG_W : dvd[BITSIZE-1:0];
    end
`ifdef SAMPLING_INVERSE_CLAMP_EN
    if (mag > CLAMP_MAG) mag = CLAMP_MAG;
`endif
    lane_res = d_q[BITSIZE] ? (BITSIZE'(0) - mag) : mag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state sequencing: two fixed-length iterative phases per lane.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = LOAD;
      LOAD:    state_nx = SQRT;
      SQRT:    if (cnt == '0) state_nx = DIV;
      DIV:     if (cnt == '0) state_nx = STORE;
      STORE:   state_nx = (lane == LW'(N_input - 1)) ? DONE : LOAD;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, per-lane sqrt/divide iterations and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      ac_q  <= '0;
      ad_q  <= '0;
      lane  <= '0;
      cnt   <= '0;
      rad   <= '0;
      root  <= '0;
      rem   <= '0;
      dvd   <= '0;
      d_q   <= '0;
      eps_q <= '0;
      err_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            ac_q <= ac;
            ad_q <= ad;
            lane <= '0;
          end
        end
        LOAD: begin
          d_q  <= d_calc;
          rad  <= ad_i[BITSIZE-1] ? '0 : {ad_i[BITSIZE-2:0], {FRAC{1'b0}}};
          root <= '0;
          rem  <= '0;
          cnt  <= CW'(SW - 1);
        end
        SQRT: begin
          rad <= {rad[RW-3:0], 2'b00};
          if (sq_ge) begin
            rem  <= RMW'(sq_rem - sq_trial);
            root <= {root[SW-2:0], 1'b1};
          end else begin
            rem  <= RMW'(sq_rem);
            root <= {root[SW-2:0], 1'b0};
          end
          if (cnt == '0) begin
            cnt <= CW'(DW - 1);
            dvd <= {d_mag, {FRAC{1'b0}}};
            rem <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          dvd <= {dvd[DW-2:0], dv_ge};
          rem <= dv_ge ? RMW'(dv_rem - dv_div) : RMW'(dv_rem);
          cnt <= cnt - 1'b1;
        end
        STORE: begin
          for (int i = 0; i < N_input; i++) begin
            if (lane == LW'(i)) begin
              eps_q[i*BITSIZE +: BITSIZE] <= lane_res;
              err_q[i]                    <= (root == '0);
            end
          end
          if (lane != LW'(N_input - 1)) lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sampling_inverse.sv
// Randomized and directed bench for sampling_inverse against an arithmetic reference model.
// Checks reset state, latency, lane results, div_err, back-pressure hold and mid-calculation reset.
// Honours SAMPLING_INVERSE_CLAMP_EN the same way as the design.
module tb_sampling_inverse;
  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [N*W-1:0] a, ac, ad;
  logic           out_valid, out_ready;
  logic [N*W-1:0] epsilon;
  logic [N-1:0]   div_err;

  int checks = 0;
  int errors = 0;
  logic [N*W-1:0] exp_eps;
  logic [N-1:0]   exp_err;

  sampling_inverse #(.N_input(N), .BITSIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .ac(ac), .ad(ad),
    .out_valid(out_valid), .out_ready(out_ready),
    .epsilon(epsilon), .div_err(div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint lo = 0;
    longint hi = longint'(1) << 31;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // eps = (a - ac) / sqrt(ad) in Q4.27, truncated, saturated, optionally clamped.
  function automatic void model_lane(input logic [31:0] av, input logic [31:0] acv,
                                     input logic [31:0] adv,
                                     output logic [31:0] res, output logic err);
    longint d    = longint'($signed(av)) - longint'($signed(acv));
    longint adv_s = longint'($signed(adv));
    longint maxv = (longint'(1) << 31) - 1;
    longint mag, s;
    if (adv_s <= 0) begin
      err = 1'b1;
      mag = (d == 0) ? 0 : maxv;
    end else begin
      err = 1'b0;
      s   = isqrt(adv_s * (longint'(1) << 27));
      mag = ((d < 0) ? -d : d) * (longint'(1) << 27) / s;
      if (mag > maxv) mag = maxv;
    end
`ifdef SAMPLING_INVERSE_CLAMP_EN
    if (mag > (longint'(1) << 29)) mag = longint'(1) << 29;
`endif
    res = 32'((d < 0) ? -mag : mag);
  endfunction

  task automatic accept(input logic [N*W-1:0] av, input logic [N*W-1:0] acv,
                        input logic [N*W-1:0] adv, input string tag);
    int waitc = 0;
    logic [31:0] r;
    logic        e;
    while (!in_ready && waitc < 300) begin
      @(posedge clk); #1; waitc++;
    end
    chk({tag, " in_ready_before"}, in_ready, 1'b1);
    for (int i = 0; i < N; i++) begin
      model_lane(av[i*W +: W], acv[i*W +: W], adv[i*W +: W], r, e);
      exp_eps[i*W +: W] = r;
      exp_err[i]        = e;
    end
    @(negedge clk);
    a = av; ac = acv; ad = adv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a  = {$urandom, $urandom};
    ac = {$urandom, $urandom};
    ad = {$urandom, $urandom};
    chk({tag, " in_ready_busy"}, in_ready, 1'b0);
  endtask

  task automatic run_bundle(input logic [N*W-1:0] av, input logic [N*W-1:0] acv,
                            input logic [N*W-1:0] adv, input string tag);
    int cyc = 0;
    accept(av, acv, adv, tag);
    while (!out_valid && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " latency"}, cyc, 90 * N);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s eps%0d", tag, i), epsilon[i*W +: W], exp_eps[i*W +: W]);
    chk({tag, " div_err"}, div_err, exp_err);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, out_valid, 1'b0);
    chk({tag, " in_ready_back"}, in_ready, 1'b1);
  endtask

  function automatic logic [N*W-1:0] pk(input logic [31:0] l0, input logic [31:0] l1);
    return {l1, l0};
  endfunction

  initial begin
    logic [31:0] ra, rac, rad;
    logic [N*W-1:0] va, vac, vad;
    int kind;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; ac = '0; ad = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst epsilon", epsilon, '0);
    chk("rst div_err", div_err, '0);
    @(negedge clk); rst_n = 1'b1;

    // 2.0/2.0 = 1.0 and -0.5/0.5 = -1.0
    run_bundle(pk(32'h18000000, 32'h00000000), pk(32'h08000000, 32'h04000000),
               pk(32'h20000000, 32'h02000000), "basic");
    chk("basic const eps0", epsilon[W-1:0], 32'h08000000);
    chk("basic const eps1", epsilon[2*W-1:W], 32'hF8000000);
    chk("basic const err", div_err, 2'b00);

    // Back-pressure: results held, in_valid ignored.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = {$urandom, $urandom}; ac = {$urandom, $urandom}; ad = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp epsilon", epsilon, exp_eps);
      chk("bp div_err", div_err, exp_err);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Zero and negative variance.
    run_bundle(pk(32'h08000000, 32'h12345678), pk(32'h00000000, 32'h12345678),
               pk(32'h00000000, 32'hF0000000), "zerovar");
`ifdef SAMPLING_INVERSE_CLAMP_EN
    chk("zerovar const eps0", epsilon[W-1:0], 32'h20000000);
`else
    chk("zerovar const eps0", epsilon[W-1:0], 32'h7FFFFFFF);
`endif
    chk("zerovar const eps1", epsilon[2*W-1:W], 32'h00000000);
    chk("zerovar const err", div_err, 2'b11);
    release_out("zerovar");

    // +6.0 and -6.0 with unit variance: clamp boundary.
    run_bundle(pk(32'h30000000, 32'hD0000000), pk(32'h0, 32'h0),
               pk(32'h08000000, 32'h08000000), "clamp");
`ifdef SAMPLING_INVERSE_CLAMP_EN
    chk("clamp const eps0", epsilon[W-1:0], 32'h20000000);
    chk("clamp const eps1", epsilon[2*W-1:W], 32'hE0000000);
`else
    chk("clamp const eps0", epsilon[W-1:0], 32'h30000000);
    chk("clamp const eps1", epsilon[2*W-1:W], 32'hD0000000);
`endif
    release_out("clamp");

    // Reset during SQRT of lane 1 aborts everything.
    accept(pk(32'h08000000, 32'h10000000), pk(32'h0, 32'h0),
           pk(32'h08000000, 32'h08000000), "midrst");
    repeat (100) @(posedge clk);
    #1;
    chk("midrst busy", out_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst in_ready", in_ready, 1'b1);
    chk("midrst epsilon", epsilon, '0);
    chk("midrst div_err", div_err, '0);
    @(negedge clk); rst_n = 1'b1;
    run_bundle(pk(32'h18000000, 32'h00000000), pk(32'h08000000, 32'h04000000),
               pk(32'h20000000, 32'h02000000), "after_rst");
    release_out("after_rst");

    // Randomized bundles.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       rad = $urandom;
          1:       rad = $urandom_range(1, 1 << 20);
          2:       rad = $urandom_range(32'h01000000, 32'h20000000);
          default: rad = 32'h0;
        endcase
        if ($urandom_range(0, 1) == 0) begin
          ra = $urandom; rac = $urandom;
        end else begin
          ra  = $urandom_range(0, 32'h0FFFFFFF) - 32'h08000000;
          rac = $urandom_range(0, 32'h0FFFFFFF) - 32'h08000000;
        end
        va[i*W +: W] = ra; vac[i*W +: W] = rac; vad[i*W +: W] = rad;
      end
      run_bundle(va, vac, vad, $sformatf("rand%0d", t));
      release_out($sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
